// File: rtl/ray_sphere_intersect.sv
`default_nettype none
// ============================================================================
// Module      : ray_sphere_intersect
// Description : Multi-cycle Q8.4 ray/sphere intersection, nearest t > TMIN.
//               Optional macro RAYSPHERE_INSIDE_HIT_EN enables the exit-point
//               (t1) fallback for origins inside the sphere.
// Revision    : 1.0 - initial release
// ============================================================================
module ray_sphere_intersect #(
    parameter int WIDTH = 12,
    parameter int TAG_W = 4,
    parameter int TMIN  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] ox,
    input  logic signed [WIDTH-1:0] oy,
    input  logic signed [WIDTH-1:0] oz,
    input  logic signed [WIDTH-1:0] dx,
    input  logic signed [WIDTH-1:0] dy,
    input  logic signed [WIDTH-1:0] dz,
    input  logic signed [WIDTH-1:0] cx,
    input  logic signed [WIDTH-1:0] cy,
    input  logic signed [WIDTH-1:0] cz,
    input  logic signed [WIDTH-1:0] r,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    hit,
    output logic signed [WIDTH-1:0] t,
    output logic [TAG_W-1:0]        out_tag
);

    localparam int c_IW   = 2*WIDTH + 2;
    localparam int c_OW   = WIDTH + 1;
    localparam int c_SQ_N = c_IW / 2;
    localparam int c_RW   = c_SQ_N + 4;
    localparam logic [3:0] c_MUL_LAST = 4'd7;
    localparam logic [3:0] c_SQ_LAST  = 4'(c_SQ_N - 1);
    localparam logic signed [c_IW-1:0] c_T_HI = c_IW'(2**(WIDTH-1) - 1);
    localparam logic signed [c_IW-1:0] c_T_LO = ~c_T_HI;
    localparam logic signed [c_IW-1:0] c_TMIN = c_IW'(TMIN);

    typedef enum logic [2:0] {
        S_IDLE, S_SUB, S_MUL, S_DISC, S_SQRT, S_RESOLVE, S_OUT
    } state_t;

    state_t r_state, w_state_nxt;

    logic [3:0]              r_cnt;
    logic signed [WIDTH-1:0] r_ox, r_oy, r_oz, r_dx, r_dy, r_dz;
    logic signed [WIDTH-1:0] r_cx, r_cy, r_cz, r_r;
    logic [TAG_W-1:0]        r_tag, r_out_tag;
    logic signed [c_OW-1:0]  r_ocx, r_ocy, r_ocz;
    logic signed [c_IW-1:0]  r_acc, r_b4, r_c8;
    logic [c_IW-1:0]         r_sq_val;
    logic                    r_neg;
    logic [c_RW-1:0]         r_rem;
    logic [c_SQ_N-1:0]       r_root;
    logic                    r_hit;
    logic signed [WIDTH-1:0] r_t;

    logic signed [c_IW-1:0]  w_ma, w_mb, w_prod, w_sum, w_disc;
    logic [c_RW-1:0]         w_rem_sh, w_trial;
    logic                    w_ge;
    logic signed [c_IW-1:0]  w_root_s, w_t0;
`ifdef RAYSPHERE_INSIDE_HIT_EN
    logic signed [c_IW-1:0]  w_t1;
`endif
    logic                    w_res_hit;
    logic signed [WIDTH-1:0] w_res_t;

    function automatic logic signed [WIDTH-1:0] sat_t(input logic signed [c_IW-1:0] v);
        if (v > c_T_HI)
            return c_T_HI[WIDTH-1:0];
        else if (v < c_T_LO)
            return c_T_LO[WIDTH-1:0];
        else
            return v[WIDTH-1:0];
    endfunction

    // Single shared multiplier; the MUL step counter selects the operand pair
    always_comb begin
        w_ma = '0;
        w_mb = '0;
        case (r_cnt[2:0])
            3'd0:    begin w_ma = c_IW'(r_ocx); w_mb = c_IW'(r_dx);  end
            3'd1:    begin w_ma = c_IW'(r_ocy); w_mb = c_IW'(r_dy);  end
            3'd2:    begin w_ma = c_IW'(r_ocz); w_mb = c_IW'(r_dz);  end
            3'd3:    begin w_ma = c_IW'(r_ocx); w_mb = c_IW'(r_ocx); end
            3'd4:    begin w_ma = c_IW'(r_ocy); w_mb = c_IW'(r_ocy); end
            3'd5:    begin w_ma = c_IW'(r_ocz); w_mb = c_IW'(r_ocz); end
            3'd6:    begin w_ma = c_IW'(r_r);   w_mb = c_IW'(r_r);   end
            default: begin w_ma = r_b4;         w_mb = r_b4;         end
        endcase
        w_prod = w_ma * w_mb;
        w_sum  = r_acc + w_prod;
        w_disc = r_acc - r_c8;
    end

    always_comb begin
        w_rem_sh = {r_rem[c_RW-3:0], r_sq_val[c_IW-1:c_IW-2]};
        w_trial  = c_RW'({r_root, 2'b01});
        w_ge     = (w_rem_sh >= w_trial);
    end

    always_comb begin
        w_root_s  = signed'(c_IW'(r_root));
        w_t0      = -r_b4 - w_root_s;
`ifdef RAYSPHERE_INSIDE_HIT_EN
        w_t1      = -r_b4 + w_root_s;
`endif
        w_res_hit = 1'b0;
        w_res_t   = '0;
        if (r_neg) begin
            w_res_hit = 1'b0;
        end else if (w_t0 > c_TMIN) begin
            w_res_hit = 1'b1;
            w_res_t   = sat_t(w_t0);
        end
`ifdef RAYSPHERE_INSIDE_HIT_EN
        else if (w_t1 > c_TMIN) begin
            w_res_hit = 1'b1;
            w_res_t   = sat_t(w_t1);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (in_valid) w_state_nxt = S_SUB;
            S_SUB:     w_state_nxt = S_MUL;
            S_MUL:     if (r_cnt == c_MUL_LAST) w_state_nxt = S_DISC;
            S_DISC:    w_state_nxt = S_SQRT;
            S_SQRT:    if (r_cnt == c_SQ_LAST) w_state_nxt = S_RESOLVE;
            S_RESOLVE: w_state_nxt = S_OUT;
            S_OUT:     if (out_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_ox      <= '0; r_oy <= '0; r_oz <= '0;
            r_dx      <= '0; r_dy <= '0; r_dz <= '0;
            r_cx      <= '0; r_cy <= '0; r_cz <= '0;
            r_r       <= '0;
            r_tag     <= '0;
            r_out_tag <= '0;
            r_ocx     <= '0; r_ocy <= '0; r_ocz <= '0;
            r_acc     <= '0;
            r_b4      <= '0;
            r_c8      <= '0;
            r_sq_val  <= '0;
            r_neg     <= 1'b0;
            r_rem     <= '0;
            r_root    <= '0;
            r_hit     <= 1'b0;
            r_t       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_ox <= ox; r_oy <= oy; r_oz <= oz;
                        r_dx <= dx; r_dy <= dy; r_dz <= dz;
                        r_cx <= cx; r_cy <= cy; r_cz <= cz;
                        r_r  <= r;
                        r_tag <= in_tag;
                    end
                end
                S_SUB: begin
                    r_ocx <= c_OW'(r_ox) - c_OW'(r_cx);
                    r_ocy <= c_OW'(r_oy) - c_OW'(r_cy);
                    r_ocz <= c_OW'(r_oz) - c_OW'(r_cz);
                    r_cnt <= '0;
                end
                S_MUL: begin
                    r_cnt <= r_cnt + 4'd1;
                    case (r_cnt[2:0])
                        3'd0, 3'd3:       r_acc <= w_prod;
                        3'd1, 3'd4, 3'd5: r_acc <= w_sum;
                        3'd2:             r_b4  <= w_sum >>> 4;
                        3'd6:             r_c8  <= r_acc - w_prod;
                        default:          r_acc <= w_prod;
                    endcase
                end
                S_DISC: begin
                    r_neg    <= w_disc[c_IW-1];
                    r_sq_val <= w_disc[c_IW-1] ? '0 : w_disc;
                    r_rem    <= '0;
                    r_root   <= '0;
                    r_cnt    <= '0;
                end
                S_SQRT: begin
                    // Restoring square root: one result bit per pair of radicand bits
                    r_rem    <= w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
                    r_root   <= {r_root[c_SQ_N-2:0], w_ge};
                    r_sq_val <= r_sq_val << 2;
                    r_cnt    <= r_cnt + 4'd1;
                end
                S_RESOLVE: begin
                    r_hit     <= w_res_hit;
                    r_t       <= w_res_t;
                    r_out_tag <= r_tag;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign hit       = r_hit;
    assign t         = r_t;
    assign out_tag   = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_ray_sphere_intersect.sv
`default_nettype none
// Testbench for ray_sphere_intersect: directed test-plan cases plus randomized
// rays checked against a plain-arithmetic reference model.
module tb_ray_sphere_intersect;

    localparam int WIDTH = 12;
    localparam int TAG_W = 4;
    localparam int TMIN  = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [WIDTH-1:0] ox = '0, oy = '0, oz = '0;
    logic signed [WIDTH-1:0] dx = '0, dy = '0, dz = '0;
    logic signed [WIDTH-1:0] cx = '0, cy = '0, cz = '0;
    logic signed [WIDTH-1:0] r = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic hit;
    logic signed [WIDTH-1:0] t;
    logic [TAG_W-1:0] out_tag;

    int errors = 0;
    int checks = 0;
    int ticks = 0;
    int acc_tick = 0;
    int last_out = 0;

    ray_sphere_intersect #(.WIDTH(WIDTH), .TAG_W(TAG_W), .TMIN(TMIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ox(ox), .oy(oy), .oz(oz),
        .dx(dx), .dy(dy), .dz(dz),
        .cx(cx), .cy(cy), .cz(cz),
        .r(r), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .hit(hit), .t(t), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        ticks++;
    endtask

    task automatic chk(input string nm, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", nm, obs, exp);
        end
    endtask

    // Reference: nearest t along the ray from the quadratic, plain integer maths
    function automatic void model(input int pox, poy, poz, pdx, pdy, pdz,
                                  input int pcx, pcy, pcz, pr,
                                  output int eh, output int et);
        longint ocx, ocy, ocz, b, b4, c8, disc, rt, t0, t1, tt;
        ocx = pox - pcx; ocy = poy - pcy; ocz = poz - pcz;
        b   = ocx*pdx + ocy*pdy + ocz*pdz;
        b4  = b >>> 4;
        c8  = ocx*ocx + ocy*ocy + ocz*ocz - longint'(pr)*pr;
        disc = b4*b4 - c8;
        eh = 0; et = 0;
        if (disc < 0) return;
        rt = 0;
        while ((rt+1)*(rt+1) <= disc) rt++;
        t0 = -b4 - rt;
        t1 = -b4 + rt;
        if (t0 > TMIN) begin
            eh = 1; tt = t0;
        end
`ifdef RAYSPHERE_INSIDE_HIT_EN
        else if (t1 > TMIN) begin
            eh = 1; tt = t1;
        end
`endif
        else return;
        if (tt > 2047) tt = 2047;
        if (tt < -2048) tt = -2048;
        et = int'(tt);
    endfunction

    task automatic send(input int pox, poy, poz, pdx, pdy, pdz, pcx, pcy, pcz, pr, tg);
        int g;
        ox = WIDTH'(pox); oy = WIDTH'(poy); oz = WIDTH'(poz);
        dx = WIDTH'(pdx); dy = WIDTH'(pdy); dz = WIDTH'(pdz);
        cx = WIDTH'(pcx); cy = WIDTH'(pcy); cz = WIDTH'(pcz);
        r  = WIDTH'(pr);
        in_tag = TAG_W'(tg);
        in_valid = 1'b1;
        g = 0;
        while (in_ready !== 1'b1 && g < 100) begin
            tick();
            g++;
        end
        if (g >= 100) chk("accept_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        acc_tick = ticks;
        {ox, oy, oz} = 36'($urandom);
        {cx, cy, cz} = 36'($urandom);
        r = WIDTH'($urandom);
        in_tag = TAG_W'($urandom);
    endtask

    task automatic recv(input string nm, input int eh, input int et, input int etag);
        int g;
        g = 0;
        while (out_valid !== 1'b1 && g < 200) begin
            tick();
            g++;
        end
        if (g >= 200) chk({nm, "_timeout"}, 0, 1);
        last_out = ticks;
        chk({nm, "_latency"}, ticks - acc_tick + 1, 25);
        chk({nm, "_hit"}, hit, eh);
        chk({nm, "_t"}, t, et);
        chk({nm, "_tag"}, out_tag, etag);
    endtask

    initial begin
        int dtab [0:8][0:2] = '{'{16,0,0}, '{-16,0,0}, '{0,16,0}, '{0,-16,0},
                                '{0,0,16}, '{0,0,-16}, '{9,9,9}, '{0,11,-11}, '{11,-11,0}};
        int prev, cnt, eh, et, di, s, tg;
        int rox, roy, roz, rcx, rcy, rcz, rr;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_hit", hit, 0);
        chk("rst_t", t, 0);
        chk("rst_out_tag", out_tag, 0);

        // Plain hit, then hold the result under backpressure
        send(0,0,0, 0,0,16, 0,0,80, 16, 5);
        recv("hit", 1, 64, 5);
        out_ready = 1'b0;
        ox = '0; oy = '0; oz = '0; dx = '0; dy = '0; dz = 12'sd16;
        cx = '0; cy = '0; cz = 12'sd40; r = 12'sd16; in_tag = 4'd9;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_t", t, 64);
            chk("bp_tag", out_tag, 5);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid === 1'b1) cnt++;
        end
        chk("bp_ignored_request", cnt, 0);

        send(0,0,0, 0,0,16, 48,0,80, 16, 2);
        recv("miss_neg", 0, 0, 2);
        send(0,0,0, 0,0,16, 16,0,80, 16, 3);
        recv("tangent", 1, 80, 3);
        send(0,0,0, 0,0,16, 0,0,-80, 16, 4);
        recv("behind", 0, 0, 4);
        send(0,0,0, 0,0,16, 0,0,0, 32, 6);
`ifdef RAYSPHERE_INSIDE_HIT_EN
        recv("inside", 1, 32, 6);
`else
        recv("inside", 0, 0, 6);
`endif

        // Reset in the middle of a request
        send(0,0,0, 0,0,16, 0,0,80, 16, 7);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_hit", hit, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_in_ready", in_ready, 1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid === 1'b1) cnt++;
        end
        chk("midrst_no_stale", cnt, 0);

        // Back-to-back with out_ready held high
        send(0,0,0, 0,0,16, 0,0,80, 16, 1);
        recv("b2b_a", 1, 64, 1);
        prev = last_out;
        send(0,0,0, 0,0,16, 16,0,80, 16, 2);
        recv("b2b_b", 1, 80, 2);
        chk("b2b_spacing_ab", last_out - prev, 26);
        prev = last_out;
        send(0,0,0, 0,0,16, 48,0,80, 16, 3);
        recv("b2b_c", 0, 0, 3);
        chk("b2b_spacing_bc", last_out - prev, 26);

        // Randomized rays aimed near the sphere so hits and misses both occur
        for (int n = 0; n < 20; n++) begin
            di  = int'($urandom_range(8));
            rox = int'($urandom_range(600)) - 300;
            roy = int'($urandom_range(600)) - 300;
            roz = int'($urandom_range(600)) - 300;
            s   = int'($urandom_range(200)) - 40;
            rcx = rox + (dtab[di][0] * s) / 16 + int'($urandom_range(80)) - 40;
            rcy = roy + (dtab[di][1] * s) / 16 + int'($urandom_range(80)) - 40;
            rcz = roz + (dtab[di][2] * s) / 16 + int'($urandom_range(80)) - 40;
            rr  = int'($urandom_range(8, 120));
            if ($urandom_range(1) == 1) rr = -rr;
            tg  = int'($urandom_range(15));
            model(rox, roy, roz, dtab[di][0], dtab[di][1], dtab[di][2], rcx, rcy, rcz, rr, eh, et);
            send(rox, roy, roz, dtab[di][0], dtab[di][1], dtab[di][2], rcx, rcy, rcz, rr, tg);
            recv("rand", eh, et, tg);
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
